// File: rtl/timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : timer                                                     |
// | Desc     : Memory-mapped 32-bit timer/compare peripheral with        |
// |            programmable prescaler, free-running or one-shot mode     |
// |            and a level interrupt on counter/compare match.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module timer #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [1:0]  hb_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam logic [1:0] C_REG_CTRL   = 2'd0;
  localparam logic [1:0] C_REG_COUNT  = 2'd1;
  localparam logic [1:0] C_REG_CMP    = 2'd2;
  localparam logic [1:0] C_REG_STATUS = 2'd3;
  localparam logic [1:0] C_HB_WORD    = 2'b00;

  // Register state
  logic               en_q, en_d;
  logic               ar_q, ar_d;
  logic               ie_q, ie_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]        count_q, count_d;
  logic [31:0]        cmp_q, cmp_d;
  logic               match_q, match_d;

  // Decode and event wires
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_cmp;
  logic        w_wr_status;
  logic        w_tick;
  logic        w_hit;
  logic [31:0] w_ctrl_rd;

  // Only address bits [3:2] select a register
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

  // Only full-word writes update registers; sub-word writes are dropped
  assign w_wr        = cs_i & we_i & (hb_i == C_HB_WORD);
  assign w_wr_ctrl   = w_wr & (addr_i[3:2] == C_REG_CTRL);
  assign w_wr_count  = w_wr & (addr_i[3:2] == C_REG_COUNT);
  assign w_wr_cmp    = w_wr & (addr_i[3:2] == C_REG_CMP);
  assign w_wr_status = w_wr & (addr_i[3:2] == C_REG_STATUS);

  // Tick every PRESCALE+1 enabled cycles; a match is a tick with COUNT==CMP
  assign w_tick = en_q & (pcnt_q == presc_q);
  assign w_hit  = w_tick & (count_q == cmp_q);

  // Next-state logic: bus writes take priority over counting side effects,
  // except a new match, which beats a simultaneous MATCH clear
  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    ie_d    = ie_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;

    // Prescaler: held at zero while disabled, restarted by any CTRL write
    if (w_wr_ctrl || !en_q || w_tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end

    // Counter: compare uses current COUNT/CMP; a COUNT write overrides
    if (w_tick) begin
      if (w_hit) begin
        if (ar_q) begin
          count_d = 32'h0;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end
    if (w_wr_count) begin
      count_d = wdata_i;
    end

    if (w_wr_ctrl) begin
      en_d    = wdata_i[0];
      ar_d    = wdata_i[1];
      ie_d    = wdata_i[2];
      presc_d = wdata_i[8 +: PRESC_W];
    end

    if (w_wr_cmp) begin
      cmp_d = wdata_i;
    end

    // MATCH is write-one-to-clear; set has priority
    if (w_hit) begin
      match_d = 1'b1;
    end else if (w_wr_status && wdata_i[0]) begin
      match_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      presc_q <= '0;
      pcnt_q  <= '0;
      count_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      match_q <= 1'b0;
    end else begin
      en_q    <= en_d;
      ar_q    <= ar_d;
      ie_q    <= ie_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  // CTRL read image; undefined bits read as zero
  always_comb begin
    w_ctrl_rd               = 32'h0;
    w_ctrl_rd[0]            = en_q;
    w_ctrl_rd[1]            = ar_q;
    w_ctrl_rd[2]            = ie_q;
    w_ctrl_rd[8 +: PRESC_W] = presc_q;
  end

  // Combinational read mux, zero when not selected
  always_comb begin
    rdata_o = 32'h0;
    if (cs_i) begin
      case (addr_i[3:2])
        C_REG_CTRL:   rdata_o = w_ctrl_rd;
        C_REG_COUNT:  rdata_o = count_q;
        C_REG_CMP:    rdata_o = cmp_q;
        C_REG_STATUS: rdata_o = {31'h0, match_q};
        default:      rdata_o = 32'h0;
      endcase
    end
  end

  assign irq_o = match_q & ie_q;

endmodule
`default_nettype wire
